// File: rtl/key_expand_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one schedule word per cycle, with RotWord/SubWord
// borrowed from a shared sub_word unit through a req/gnt handshake.
module key_expand_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_key,
    output logic         o_sw_req,
    input  logic         i_sw_gnt,
    output logic [31:0]  o_sw_word,
    input  logic [31:0]  i_sw_word,
    output logic         o_busy,
    output logic         o_rk_valid,
    output logic [3:0]   o_rk_idx,
    output logic [127:0] o_rk,
    output logic         o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2
    } state_t;

    localparam int LAST_I = 4 * (NUM_ROUNDS + 1) - 1;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] v;
        case (n)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    // r_win[0] is the newest word w[i-1], r_win[3] the oldest w[i-4]; packed order matches i_key
    logic [3:0][31:0] r_win;
    logic [5:0]      r_cnt;
    logic            r_busy;
    logic            r_rk_valid;
    logic [3:0]      r_rk_idx;
    logic [127:0]    r_rk;
    logic            r_done;

    logic            w_req;
    logic            w_commit;
    logic            w_last_word;
    logic            w_last_round;
    logic [31:0]     w_rot;
    logic [31:0]     w_temp;
    logic [31:0]     w_new;

    assign w_rot        = {r_win[0][23:0], r_win[0][31:24]};
    assign w_last_word  = (r_cnt[1:0] == 2'b11);
    assign w_last_round = (r_cnt == 6'(LAST_I));

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_commit    = 1'b0;
        w_temp      = r_win[0];
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_EXPAND;
            end
            S_EXPAND: begin
                w_req    = (r_cnt[1:0] == 2'b00);
                // a word needing SubWord waits for the shared unit; i and the window hold meanwhile
                w_commit = !w_req || i_sw_gnt;
                if (w_req) w_temp = i_sw_word ^ {rcon(r_cnt[5:2]), 24'h0};
                if (w_commit && w_last_word && w_last_round) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_new = r_win[3] ^ w_temp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_idx   <= '0;
            r_rk       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_win  <= i_key;
                        r_cnt  <= 6'd4;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_rk       <= r_win;
                    r_rk_idx   <= 4'd0;
                    r_rk_valid <= 1'b1;
                end
                S_EXPAND: begin
                    if (w_commit) begin
                        r_win <= {r_win[2:0], w_new};
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last_word) begin
                            r_rk       <= {r_win[2:0], w_new};
                            r_rk_idx   <= r_cnt[5:2];
                            r_rk_valid <= 1'b1;
                            if (w_last_round) begin
                                r_done <= 1'b1;
                                r_busy <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sw_req   = w_req;
    assign o_sw_word  = w_req ? w_rot : 32'h0;
    assign o_busy     = r_busy;
    assign o_rk_valid = r_rk_valid;
    assign o_rk_idx   = r_rk_idx;
    assign o_rk       = r_rk;
    assign o_done     = r_done;

endmodule
